// File: rtl/eda_local_max_scan.sv
// eda_local_max_scan: sweeps the center address over an M x N image held in the
// upstream window RAM, classifies each pixel as a regional-max candidate from its
// 3x3 window and emits one result per pixel on a valid/ready stream.
module eda_local_max_scan #(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9,
  parameter int ADDR_WIDTH   = $clog2(M * N)
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_start,
  output logic [ADDR_WIDTH-1:0]               o_center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] i_window_values,
  input  logic [WINDOW_WIDTH-2:0]             i_neigh_addr_valid,
  output logic                                o_out_valid,
  input  logic                                i_out_ready,
  output logic [ADDR_WIDTH-1:0]               o_out_addr,
  output logic                                o_out_is_max,
  output logic                                o_out_plateau,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [ADDR_WIDTH:0]                 o_max_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Address of the final pixel; the sweep stops here so the RAM never sees
  // an address past the image even when M*N is not a power of two.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(M * N - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

  // Window slots from LSB: 0=downright 1=down 2=downleft 3=right 4=center
  // 5=left 6=upright 7=up 8=upleft. Neighbour j (mask bit j) lives in slot j
  // below the center and slot j+1 above it.
  // Returns {is_max, plateau}; masked-off neighbours take no part.
  function automatic logic [1:0] classify(
    input logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] win,
    input logic [WINDOW_WIDTH-2:0]             mask
  );
    logic [PIXEL_WIDTH-1:0] ctr;
    logic [PIXEL_WIDTH-1:0] nb;
    logic                   ge_all;
    logic                   eq_any;
    ctr    = win[(WINDOW_WIDTH / 2) * PIXEL_WIDTH +: PIXEL_WIDTH];
    ge_all = 1'b1;
    eq_any = 1'b0;
    for (int j = 0; j < WINDOW_WIDTH - 1; j++) begin
      nb = win[((j < 4) ? j : j + 1) * PIXEL_WIDTH +: PIXEL_WIDTH];
      if (mask[j]) begin
        if (nb > ctr) begin
          ge_all = 1'b0;
        end else begin
          ge_all = ge_all;
        end
        if (nb == ctr) begin
          eq_any = 1'b1;
        end else begin
          eq_any = eq_any;
        end
      end else begin
        ge_all = ge_all;
      end
    end
    return {ge_all, ge_all & eq_any};
  endfunction

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_center_addr;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_out_is_max;
  logic                  r_out_plateau;
  logic                  r_done;
  logic [ADDR_WIDTH:0]   r_max_count;

  logic [1:0]            w_class;
  logic                  w_handshake;
  logic                  w_adv;

  // Classify the current center and decode the stream handshake / advance.
  always_comb begin
    w_class     = classify(i_window_values, i_neigh_addr_valid);
    w_handshake = r_out_valid & i_out_ready;
    w_adv       = (r_state == S_SCAN) && (!r_out_valid || i_out_ready);
  end

  // Scan sequencing, address generation and the registered result slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_center_addr <= '0;
      r_out_valid   <= 1'b0;
      r_out_addr    <= '0;
      r_out_is_max  <= 1'b0;
      r_out_plateau <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
          end
          if (i_start) begin
            r_state       <= S_SCAN;
            r_center_addr <= '0;
          end
        end
        S_SCAN: begin
          if (w_adv) begin
            r_out_valid   <= 1'b1;
            r_out_addr    <= r_center_addr;
            r_out_is_max  <= w_class[1];
            r_out_plateau <= w_class[0];
            if (r_center_addr == LAST_ADDR) begin
              r_state <= S_DRAIN;
            end else begin
              r_center_addr <= r_center_addr + ADDR_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          if (w_handshake) begin
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Count accepted max candidates; cleared at scan start, held after done.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_max_count <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_max_count <= '0;
    end else if (w_handshake && r_out_is_max) begin
      r_max_count <= r_max_count + COUNT_ONE;
    end else begin
      r_max_count <= r_max_count;
    end
  end

  assign o_center_addr = r_center_addr;
  assign o_out_valid   = r_out_valid;
  assign o_out_addr    = r_out_addr;
  assign o_out_is_max  = r_out_is_max;
  assign o_out_plateau = r_out_plateau;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_max_count   = r_max_count;

endmodule

// File: tb/tb_eda_local_max_scan.sv
// Bench for eda_local_max_scan: two instances (4x4 and 3x5) fed by a window-RAM
// model, checked against a coordinate-based regional-max reference.
module tb_eda_local_max_scan;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start [2];
  logic          rdy   [2];
  logic [AW-1:0] ca    [2];
  logic [71:0]   win   [2];
  logic [7:0]    mask  [2];
  logic          vld   [2];
  logic [AW-1:0] oaddr [2];
  logic          ismax [2];
  logic          plat  [2];
  logic          busy  [2];
  logic          done  [2];
  logic [AW:0]   mcnt  [2];

  logic [7:0] img [2][16];

  int n_checks = 0;
  int n_errors = 0;

  eda_local_max_scan #(.M(4), .N(4)) dut44 (
    .i_clk(clk), .i_reset(rst), .i_start(start[0]), .o_center_addr(ca[0]),
    .i_window_values(win[0]), .i_neigh_addr_valid(mask[0]), .o_out_valid(vld[0]),
    .i_out_ready(rdy[0]), .o_out_addr(oaddr[0]), .o_out_is_max(ismax[0]),
    .o_out_plateau(plat[0]), .o_busy(busy[0]), .o_done(done[0]), .o_max_count(mcnt[0]));

  eda_local_max_scan #(.M(3), .N(5)) dut35 (
    .i_clk(clk), .i_reset(rst), .i_start(start[1]), .o_center_addr(ca[1]),
    .i_window_values(win[1]), .i_neigh_addr_valid(mask[1]), .o_out_valid(vld[1]),
    .i_out_ready(rdy[1]), .o_out_addr(oaddr[1]), .o_out_is_max(ismax[1]),
    .o_out_plateau(plat[1]), .o_busy(busy[1]), .o_done(done[1]), .o_max_count(mcnt[1]));

  function automatic int dim_m(input int b); return (b == 0) ? 4 : 3; endfunction
  function automatic int dim_n(input int b); return (b == 0) ? 4 : 5; endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window RAM model: returns {mask, window}; out-of-image bytes read as 255.
  function automatic logic [79:0] build_win(input int b, input int a);
    logic [71:0] w;
    logic [7:0]  mk;
    int m, n, r, c, rr, cc;
    m = dim_m(b); n = dim_n(b);
    w = '0; mk = '0; r = a / m; c = a % m;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (k == 4) begin
        w[32 +: 8] = img[b][a];
      end else if (rr >= 0 && rr < n && cc >= 0 && cc < m) begin
        w[(8 - k) * 8 +: 8] = img[b][rr * m + cc];
        mk[(k < 4) ? (7 - k) : (8 - k)] = 1'b1;
      end else begin
        w[(8 - k) * 8 +: 8] = 8'hFF;
      end
    end
    return {mk, w};
  endfunction

  always_comb {mask[0], win[0]} = build_win(0, int'(ca[0]));
  always_comb {mask[1], win[1]} = build_win(1, int'(ca[1]));

  // Reference: {is_max, plateau} from image coordinates.
  function automatic logic [1:0] ref_class(input int b, input int a);
    int m, n, r, c;
    bit ge, eq;
    logic [7:0] ctr, nb;
    m = dim_m(b); n = dim_n(b); r = a / m; c = a % m;
    ctr = img[b][a]; ge = 1'b1; eq = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < n && c + dc >= 0 && c + dc < m) begin
          nb = img[b][(r + dr) * m + c + dc];
          if (nb > ctr) ge = 1'b0;
          if (nb == ctr) eq = 1'b1;
        end
      end
    end
    return {ge, ge & eq};
  endfunction

  // Accepted results: {addr, is_max, plateau}
  logic [5:0] rq0 [$];
  logic [5:0] rq1 [$];
  function automatic int qsize(input int b); return (b == 0) ? rq0.size() : rq1.size(); endfunction
  function automatic logic [5:0] qget(input int b, input int i);
    if (i >= qsize(b)) return 6'h3F;
    return (b == 0) ? rq0[i] : rq1[i];
  endfunction

  int cyc = 0;
  int dcnt [2], done_cyc [2], hs_cyc [2], max_ca [2];
  logic          pv [2], pr [2], pbusy [2], pmx [2], ppl [2];
  logic [AW-1:0] paddr [2], pca [2];
  logic          prst = 1'b1;

  // Monitor: collect handshakes, done pulses, stall stability and address stepping.
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!prst && pv[b] && !pr[b]) begin
        check_eq("stall_valid", 32'(vld[b]), 32'd1);
        check_eq("stall_addr", 32'(oaddr[b]), 32'(paddr[b]));
        check_eq("stall_flags", 32'({ismax[b], plat[b]}), 32'({pmx[b], ppl[b]}));
      end
      if (!prst && pbusy[b] && busy[b] && ca[b] != pca[b]) begin
        check_eq("adv_only", 32'(!pv[b] || pr[b]), 32'd1);
        check_eq("ca_step", 32'(ca[b]), 32'(int'(pca[b]) + 1));
      end
      check_eq("ca_bound", 32'(int'(ca[b]) <= dim_m(b) * dim_n(b) - 1), 32'd1);
      if (int'(ca[b]) > max_ca[b]) max_ca[b] = int'(ca[b]);
      if (vld[b] && rdy[b]) begin
        if (b == 0) rq0.push_back({oaddr[b], ismax[b], plat[b]});
        else        rq1.push_back({oaddr[b], ismax[b], plat[b]});
        hs_cyc[b] = cyc;
      end
      if (done[b]) begin
        dcnt[b]++;
        done_cyc[b] = cyc;
      end
      pv[b] = vld[b]; pr[b] = rdy[b]; pbusy[b] = busy[b];
      pmx[b] = ismax[b]; ppl[b] = plat[b]; paddr[b] = oaddr[b]; pca[b] = ca[b];
    end
    prst = rst;
    cyc++;
  end

  function automatic logic ready_pat(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((i % 4) == 0) || ((i % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // One scan on instance b; mode selects the ready pattern. Optionally pulse
  // start again at result 7, or assert reset once rst_at results are accepted.
  task automatic run_scan(input int b, input int mode, input bit mid_start, input int rst_at);
    int nres, expmax;
    bit pulsed;
    logic [1:0] cls;
    logic [5:0] e;
    nres = dim_m(b) * dim_n(b);
    pulsed = 1'b0;
    if (b == 0) rq0.delete(); else rq1.delete();
    dcnt[b] = 0; max_ca[b] = 0; done_cyc[b] = -1; hs_cyc[b] = -1;
    @(posedge clk); #1 start[b] = 1'b1; rdy[b] = ready_pat(mode, 0);
    @(posedge clk); #1 start[b] = 1'b0;
    @(negedge clk);
    check_eq("lat_busy", 32'(busy[b]), 32'd1);
    check_eq("lat_ca0", 32'(ca[b]), 32'd0);
    check_eq("lat_nvalid", 32'(vld[b]), 32'd0);
    @(negedge clk);
    check_eq("lat_valid", 32'(vld[b]), 32'd1);
    check_eq("lat_addr0", 32'(oaddr[b]), 32'd0);
    for (int i = 1; i < 2000 && dcnt[b] == 0; i++) begin
      @(posedge clk); #1;
      rdy[b] = ready_pat(mode, i);
      if (mid_start && !pulsed && qsize(b) >= 7) begin
        start[b] = 1'b1;
        pulsed = 1'b1;
      end else begin
        start[b] = 1'b0;
      end
      if (rst_at > 0 && qsize(b) >= rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 32'(vld[b]), 32'd0);
        check_eq("rst_busy", 32'(busy[b]), 32'd0);
        check_eq("rst_mcnt", 32'(mcnt[b]), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_nodone", 32'(dcnt[b]), 32'd0);
        return;
      end
    end
    start[b] = 1'b0;
    repeat (3) @(negedge clk);
    expmax = 0;
    check_eq("n_results", 32'(qsize(b)), 32'(nres));
    for (int a = 0; a < nres; a++) begin
      cls = ref_class(b, a);
      if (cls[1]) expmax++;
      e = qget(b, a);
      check_eq("res_addr", 32'(e[5:2]), 32'(a));
      check_eq("res_is_max", 32'(e[1]), 32'(cls[1]));
      check_eq("res_plateau", 32'(e[0]), 32'(cls[0]));
    end
    check_eq("max_count", 32'(mcnt[b]), 32'(expmax));
    check_eq("done_once", 32'(dcnt[b]), 32'd1);
    check_eq("done_timing", 32'(done_cyc[b]), 32'(hs_cyc[b] + 1));
    check_eq("idle_after", 32'(busy[b]), 32'd0);
  endtask

  task automatic fill_img(input int b, input int lo, input int hi);
    for (int a = 0; a < 16; a++) img[b][a] = 8'($urandom_range(lo, hi));
  endtask

  logic [5:0] ent;

  initial begin
    rst = 1'b1;
    for (int b = 0; b < 2; b++) begin
      start[b] = 1'b0; rdy[b] = 1'b1; dcnt[b] = 0; max_ca[b] = 0;
      for (int a = 0; a < 16; a++) img[b][a] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      check_eq("rst_out_valid", 32'(vld[b]), 32'd0);
      check_eq("rst_center", 32'(ca[b]), 32'd0);
      check_eq("rst_out_addr", 32'(oaddr[b]), 32'd0);
      check_eq("rst_flags", 32'({ismax[b], plat[b]}), 32'd0);
      check_eq("rst_busy_done", 32'({busy[b], done[b]}), 32'd0);
      check_eq("rst_max_count", 32'(mcnt[b]), 32'd0);
    end

    // Flat image: every pixel is a plateau max.
    for (int a = 0; a < 16; a++) img[0][a] = 8'd5;
    run_scan(0, 0, 1'b0, 0);
    check_eq("flat_mcnt", 32'(mcnt[0]), 32'd16);
    ent = qget(0, 9);
    check_eq("flat_plateau", 32'(ent[1:0]), 32'd3);

    // Single peak at address 5.
    for (int a = 0; a < 16; a++) img[0][a] = 8'd1;
    img[0][5] = 8'd9;
    run_scan(0, 0, 1'b0, 0);
    check_eq("peak_mcnt", 32'(mcnt[0]), 32'd8);
    ent = qget(0, 5);
    check_eq("peak_center", 32'(ent[1:0]), 32'd2);
    ent = qget(0, 10);
    check_eq("peak_neigh", 32'(ent[1]), 32'd0);
    ent = qget(0, 15);
    check_eq("peak_far", 32'(ent[1:0]), 32'd3);

    // Corner masking: 255 bytes outside the image must be ignored.
    for (int a = 0; a < 16; a++) img[0][a] = 8'd1;
    img[0][0] = 8'd3; img[0][1] = 8'd4;
    run_scan(0, 0, 1'b0, 0);
    ent = qget(0, 0);
    check_eq("corner_right4", 32'(ent[1]), 32'd0);
    img[0][1] = 8'd2;
    run_scan(0, 0, 1'b0, 0);
    ent = qget(0, 0);
    check_eq("corner_right2", 32'(ent[1:0]), 32'd2);

    // Backpressure 1,0,0,1 and random ready with random images.
    fill_img(0, 0, 3);
    run_scan(0, 1, 1'b0, 0);
    fill_img(0, 0, 255);
    run_scan(0, 2, 1'b0, 0);

    // start while busy is ignored.
    fill_img(0, 0, 3);
    run_scan(0, 2, 1'b1, 0);

    // Reset mid-scan, then a fresh scan from address 0.
    fill_img(0, 0, 3);
    run_scan(0, 0, 1'b0, 10);
    run_scan(0, 2, 1'b0, 0);

    // Non power-of-two image.
    fill_img(1, 0, 3);
    run_scan(1, 0, 1'b0, 0);
    check_eq("np2_max_center", 32'(max_ca[1]), 32'd14);
    fill_img(1, 0, 2);
    run_scan(1, 1, 1'b0, 0);
    fill_img(1, 0, 255);
    run_scan(1, 2, 1'b0, 0);
    check_eq("np2_max_center2", 32'(max_ca[1]), 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eda_local_max_scan.md
Name: eda_local_max_scan

Overview:
- Scan sequencer and comparator directly downstream of the image window RAM.
- After an image is loaded, it sweeps center_addr over every pixel, 0 to M*N-1.
- For each center it takes the combinational 3x3 window and the neighbour-valid mask returned by the RAM, and classifies the center as a regional-max candidate.
- Per-pixel results go out on a valid/ready stream; a plateau flag is provided for a later flood stage.

Parameters:
- M, 16, image width in pixels (row pitch).
- N, 16, image height in rows.
- PIXEL_WIDTH, 8, unsigned pixel width.
- WINDOW_WIDTH, 9, window size; fixed 3x3.
- ADDR_WIDTH, $clog2(M*N), pixel address width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- start  in  1  one-cycle pulse that begins a scan; ignored unless state is IDLE.
- center_addr  out  ADDR_WIDTH  address driven to the window RAM.
- window_values  in  PIXEL_WIDTH*WINDOW_WIDTH  order from MSB: upleft, up, upright, left, center, right, downleft, down, downright.
- neigh_addr_valid  in  WINDOW_WIDTH-1  bit7=upleft ... bit0=downright; 1 = neighbour inside the image.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_addr  out  ADDR_WIDTH  address of the classified pixel.
- out_is_max  out  1  center >= every valid neighbour.
- out_plateau  out  1  out_is_max and center == at least one valid neighbour.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.
- max_count  out  ADDR_WIDTH+1  number of accepted results with out_is_max=1.

Behaviour:
- Reset (synchronous, active-high, priority over all else): state=IDLE; center_addr=0; out_valid=0; out_addr=0; out_is_max=0; out_plateau=0; done=0; max_count=0.
- States: IDLE, SCAN, DRAIN.
- IDLE: on start, go to SCAN, set center_addr=0, clear max_count. busy=0 only in IDLE.
- Advance condition: adv = (state==SCAN) && (!out_valid || out_ready).
- SCAN, on adv:
  - Register out_addr=center_addr, out_is_max and out_plateau from the current window, and set out_valid=1.
  - If center_addr==M*N-1, go to DRAIN with center_addr held; else center_addr++.
- SCAN, no adv (out_valid && !out_ready): hold center_addr and all out_* stable.
- DRAIN: on out_valid && out_ready, set out_valid=0, pulse done=1 for one cycle, go to IDLE.
- Any state other than the cases above: if out_valid && out_ready and no new load, out_valid=0.
- Comparison:
  - Pixels are unsigned.
  - Neighbours whose neigh_addr_valid bit is 0 are excluded from all tests.
  - If all neighbour bits are 0, out_is_max=1 and out_plateau=0.
- max_count: increments on each out_valid && out_ready with out_is_max=1. Holds its value after done until the next start.
- Latency and throughput:
  - start at cycle t gives center_addr=0 at t+1 and out_valid for address 0 at t+2.
  - One result per cycle while out_ready=1.
  - Exactly M*N results per scan, in ascending address order; no gaps, duplicates or skips under any backpressure pattern.
- start while busy: ignored, no restart.
- Reset mid-scan: immediate return to IDLE and all outputs cleared; no done pulse.
- center_addr never exceeds M*N-1, including when M*N is not a power of two.

Test Plan:
- M=N=4, all pixels 5, all valid bits driven correctly, out_ready=1:
  - 16 results, addrs 0..15 in order, all out_is_max=1 and out_plateau=1.
  - max_count=16; done pulses at the cycle after the address-15 handshake.
  - First out_valid occurs 2 cycles after start.
- M=N=4, single peak value 9 at address 5, others 1:
  - Only address 5 has out_is_max=1 with out_plateau=0.
  - Every pixel not adjacent to 5 has out_is_max=1 and out_plateau=1.
  - Neighbours of 5 have out_is_max=0.
  - max_count=8.
- Corner masking: address 0 with value 3, right=4, all invalid-neighbour window bytes driven to 255:
  - out_is_max=0, showing 255s are ignored.
  - With right=2 instead: out_is_max=1.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly:
  - out_addr and flags stay stable while stalled.
  - All 16 addresses appear exactly once.
  - center_addr advances only on adv.
- start pulsed at result 7 mid-scan: ignored, scan completes normally. Then reset asserted at result 10 of a second scan: out_valid=0 and busy=0 next cycle, no done pulse, next start scans from 0.
- M=3, N=5 (non power of two): 15 results, center_addr maxes at 14, done=1 once, max_count matches a reference model.
